// File: rtl/ln_out_stream_adapter.sv
// Buffers unthrottled LayerNorm result beats in a FIFO and replays each beat as
// RATIO narrower valid/ready words with tlast per token. Optional stats: LN_OSTREAM_STATS_EN.
module ln_out_stream_adapter #(
  parameter int unsigned IN_W            = 1024,
  parameter int unsigned OUT_W           = 256,
  parameter int unsigned BEATS_PER_TOKEN = 12,
  parameter int unsigned DEPTH           = 24
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [IN_W-1:0]            i_data_flat,
  input  logic                       i_clr_ovf,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic [OUT_W-1:0]           o_tdata,
  output logic                       o_tlast,
  output logic [$clog2(DEPTH+1)-1:0] o_fill,
  output logic                       o_overflow
`ifdef LN_OSTREAM_STATS_EN
  ,
  output logic [31:0]                o_tok_cnt,
  output logic [31:0]                o_drop_cnt
`endif
);

  localparam int unsigned RATIO   = IN_W / OUT_W;
  localparam int unsigned SLICE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCNT_W  = (BEATS_PER_TOKEN > 1) ? $clog2(BEATS_PER_TOKEN) : 1;
  localparam int unsigned FILL_W  = $clog2(DEPTH + 1);

  typedef enum logic {S_EMPTY, S_SEND} state_e;

  state_e             state_q, state_d;
  logic [IN_W:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [SLICE_W-1:0] slice_q, slice_d, slice_nx_c;
  logic [IN_W-1:0]    shreg_q, shreg_d;
  logic               last_q, last_d;
  logic               tlast_q, tlast_d;
  logic               tvalid_q, tvalid_d;
  logic               ovf_q, ovf_d;
  logic               full_c, push_c, drop_c, pop_c, hs_c, wlast_c;
  logic [IN_W:0]      head_c;

  // Write side: framing counter runs on every strobe so drops keep token alignment
  always_comb begin
    full_c  = (fill_q == FILL_W'(DEPTH));
    push_c  = i_valid && !full_c;
    drop_c  = i_valid && full_c;
    wlast_c = (wcnt_q == WCNT_W'(BEATS_PER_TOKEN - 1));
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    if (i_valid) begin
      wcnt_d = wlast_c ? '0 : wcnt_q + WCNT_W'(1);
    end
    if (push_c) begin
      wptr_d = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    rptr_d = rptr_q;
    if (pop_c) begin
      rptr_d = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    fill_d = fill_q + FILL_W'(push_c) - FILL_W'(pop_c);
    ovf_d  = (ovf_q && !i_clr_ovf) || drop_c;
    head_c = mem_q[rptr_q];
  end

  always_ff @(posedge i_clk) begin
    if (push_c) begin
      mem_q[wptr_q] <= {wlast_c, i_data_flat};
    end
  end

  // Output FSM: next state and registered stream outputs
  always_comb begin
    state_d    = state_q;
    slice_d    = slice_q;
    shreg_d    = shreg_q;
    last_d     = last_q;
    tlast_d    = tlast_q;
    tvalid_d   = tvalid_q;
    pop_c      = 1'b0;
    hs_c       = tvalid_q && i_tready;
    slice_nx_c = slice_q + SLICE_W'(1);
    unique case (state_q)
      S_EMPTY: begin
        if (fill_q != '0) begin
          pop_c    = 1'b1;
          shreg_d  = head_c[IN_W-1:0];
          last_d   = head_c[IN_W];
          slice_d  = '0;
          tlast_d  = head_c[IN_W] && (RATIO == 1);
          tvalid_d = 1'b1;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (hs_c) begin
          if (slice_q != SLICE_W'(RATIO - 1)) begin
            slice_d = slice_nx_c;
            shreg_d = shreg_q >> OUT_W;
            tlast_d = last_q && (slice_nx_c == SLICE_W'(RATIO - 1));
          end else if (fill_q != '0) begin
            pop_c    = 1'b1;
            shreg_d  = head_c[IN_W-1:0];
            last_d   = head_c[IN_W];
            slice_d  = '0;
            tlast_d  = head_c[IN_W] && (RATIO == 1);
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = S_EMPTY;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_EMPTY;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fill_q   <= '0;
      wcnt_q   <= '0;
      slice_q  <= '0;
      shreg_q  <= '0;
      last_q   <= 1'b0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fill_q   <= fill_d;
      wcnt_q   <= wcnt_d;
      slice_q  <= slice_d;
      shreg_q  <= shreg_d;
      last_q   <= last_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_tvalid   = tvalid_q;
  assign o_tdata    = shreg_q[OUT_W-1:0];
  assign o_tlast    = tlast_q;
  assign o_fill     = fill_q;
  assign o_overflow = ovf_q;

`ifdef LN_OSTREAM_STATS_EN
  logic [31:0] tok_cnt_q, drop_cnt_q;

  // Free-running statistics; only reset clears them
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tok_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (hs_c && tlast_q) tok_cnt_q <= tok_cnt_q + 32'd1;
      if (drop_c) drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign o_tok_cnt  = tok_cnt_q;
  assign o_drop_cnt = drop_cnt_q;
`endif

endmodule
